// File: rtl/io_key_port.sv
// Debounced push-button / slide-switch event port behind a 4-word CPU IO window.
// Each debounced toggle of the 13 sources is queued as a 16-bit event in a small FIFO.

module io_key_port #(
  parameter logic [15:0] BASE_ADDR       = 16'hFF10,
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter int unsigned FIFO_DEPTH      = 8
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [3:0]  keys_in,
  input  logic [9:0]  sw_in,
  input  logic [15:0] raddr,
  input  logic        rd_en,
  input  logic [15:0] waddr,
  input  logic [15:0] wdata,
  input  logic        wenable,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [3:0]    DEPTH4    = 4'(FIFO_DEPTH);

  localparam logic [15:0] ADDR_STATUS = BASE_ADDR;
  localparam logic [15:0] ADDR_EVENT  = BASE_ADDR + 16'd1;
  localparam logic [15:0] ADDR_LEVEL  = BASE_ADDR + 16'd2;

  // Sources 1-3 are the inverted keys, 4-13 the switches; 1 always means active.
  logic [13:1] raw_src;
  assign raw_src = {sw_in, ~keys_in[3:1]};

  logic unused_bits;
  assign unused_bits = ^{keys_in[0], wdata[15:4], wdata[1:0]};

  logic [13:1]   sync1_q, sync1_d, sync2_q, sync2_d;
  logic [13:1]   samp_q, samp_d, level_q, level_d, pend_q, pend_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [3:0]    count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [5:0]    mem_q [FIFO_DEPTH];

  logic        tick, empty, full, pop, push, take, flush, ovf_clr, ovf_set;
  logic [13:1] toggle, enq_mask;
  logic [4:0]  enq_idx;
  logic        enq_lvl;
  logic [5:0]  head;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sync1_d = raw_src;
    sync2_d = sync1_q;
    tick    = (presc_q == TICK_LAST);
    presc_d = tick ? '0 : presc_q + CW'(1);
    samp_d  = tick ? sync2_q : samp_q;
    toggle  = tick ? (~(sync2_q ^ samp_q) & (sync2_q ^ level_q)) : '0;
    level_d = level_q ^ toggle;
  end

  // Lowest pending index wins: scan downward so the last hit is the smallest.
  always_comb begin
    enq_idx  = '0;
    enq_lvl  = 1'b0;
    enq_mask = '0;
    for (int i = 13; i >= 1; i--) begin
      if (pend_q[i]) begin
        enq_idx     = 5'(i);
        enq_lvl     = level_q[i];
        enq_mask    = '0;
        enq_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    head    = mem_q[rd_ptr_q];
    empty   = (count_q == 4'd0);
    full    = (count_q == DEPTH4);
    flush   = wenable && (waddr == ADDR_STATUS) && wdata[3];
    ovf_clr = wenable && (waddr == ADDR_STATUS) && wdata[2];
    pop     = rd_en && (raddr == ADDR_EVENT) && !empty;
    // A flush holds off the enqueue so the pending bit survives the flush.
    take    = (|pend_q) && !flush;
    push    = take && (!full || pop);
    ovf_set = take && full && !pop;
    ovf_d   = ovf_set || (ovf_q && !ovf_clr);
    pend_d  = (pend_q & ~(take ? enq_mask : '0)) | toggle;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = 4'd0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end

    rdata_d = 16'h0000;
    if (rd_en) begin
      if (raddr == ADDR_STATUS)
        rdata_d = {8'h00, count_q, 1'b0, ovf_q, full, !empty};
      else if (raddr == ADDR_EVENT && !empty)
        rdata_d = {head[5], 10'b0, head[4:0]};
      else if (raddr == ADDR_LEVEL)
        rdata_d = {2'b00, level_q, 1'b0};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      samp_q   <= '0;
      level_q  <= '0;
      pend_q   <= '0;
      presc_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      rdata_q  <= 16'h0000;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      samp_q   <= samp_d;
      level_q  <= level_d;
      pend_q   <= pend_d;
      presc_q  <= presc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      rdata_q  <= rdata_d;
    end
  end

  // NOTE: the entry storage is not reset; count and pointers gate every read of it.
  always_ff @(posedge CLOCK_50) begin
    if (push) mem_q[wr_ptr_q] <= {enq_lvl, enq_idx};
  end

  assign rdata = rdata_q;
  assign irq   = !empty;

endmodule

// File: doc/io_key_port.md
IO_KEY_PORT -- requirements
Module: io_key_port

Interface
REQ-001 Parameter BASE_ADDR, default 16'hFF10: base of the 4-word IO window.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: sample-tick period in clocks, giving 5 ms at 50 MHz.
REQ-003 Parameter FIFO_DEPTH, default 8: number of event-FIFO entries; power of two, at most 8.
REQ-004 CLOCK_50  in  1  sole clock; all logic is clocked on its rising edge.
REQ-005 reset  in  1  synchronous active-low reset.
REQ-006 keys_in  in  4  raw push buttons, active low; bit 0 is unused by the event logic and is reported as idle.
REQ-007 sw_in  in  10  raw slide switches, active high.
REQ-008 raddr  in  16  read address from the CPU io bus.
REQ-009 rd_en  in  1  one-cycle read strobe qualifying raddr.
REQ-010 waddr  in  16  write address.
REQ-011 wdata  in  16  write data.
REQ-012 wenable  in  1  one-cycle write strobe.
REQ-013 rdata  out  16  registered read data; 16'h0000 when the window is not addressed.
REQ-014 irq  out  1  high while the FIFO is not empty.

Function
REQ-015 Each of the 13 sources SHALL pass through a 2-FF synchronizer: keys_in[3:1] are sources 1-3 and are inverted so that 1 means pressed; sw_in[9:0] are sources 4-13.
REQ-016 A prescaler SHALL assert a one-cycle tick every DEBOUNCE_CYCLES clocks, wrapping from DEBOUNCE_CYCLES-1 to 0.
REQ-017 On each tick, the synchronized value SHALL be captured into a sample register.
REQ-018 A source's debounced level SHALL toggle on a tick when the current capture equals the previous capture and differs from the debounced level.
REQ-019 Every debounced toggle SHALL set that source's pending bit.
REQ-020 The enqueue logic SHALL take one pending bit per cycle, lowest index first, and clear it in the same cycle.
REQ-021 The enqueued entry SHALL be 16 bits: [15] = new level (1 = pressed/on), [14:5] = 0, [4:0] = source index.
REQ-022 If the FIFO is full and no pop occurs in the same cycle, the event SHALL be dropped, the overflow flag set (sticky), and the pending bit still cleared.
REQ-023 A push and a pop in the same cycle SHALL both take effect; a push while full with a simultaneous pop SHALL be accepted and SHALL NOT set overflow.
REQ-024 Read BASE+0 (STATUS) SHALL return [0] not_empty, [1] full, [2] overflow, [7:4] count, other bits 0.
REQ-025 Read BASE+1 (EVENT) SHALL return the FIFO head and pop it; when the FIFO is empty it SHALL return 16'h0000 and SHALL NOT pop.
REQ-026 Read BASE+2 (LEVEL) SHALL return the 13 debounced levels in bits [13:1], with bits 0, 14 and 15 reading 0.
REQ-027 Read BASE+3 SHALL return 16'h0000.
REQ-028 rdata SHALL update on the clock edge that samples rd_en, so read latency is 1 cycle.
REQ-029 Cycles without rd_en, or with raddr outside the window, SHALL load rdata with 16'h0000.
REQ-030 A write to BASE+0 with wdata[2]=1 SHALL clear overflow.
REQ-031 A write to BASE+0 with wdata[3]=1 SHALL flush the FIFO: count becomes 0; pending bits are unaffected.
REQ-032 All other writes SHALL be ignored.
REQ-033 If an overflow clear and an overflow set occur in the same cycle, set SHALL win.
REQ-034 Pointer arithmetic SHALL be modulo FIFO_DEPTH; count SHALL be 4 bits and range 0..FIFO_DEPTH.

Reset
REQ-035 When reset is low at a clock edge, the following SHALL clear: FIFO count, pointers, overflow, pending bits, prescaler, rdata = 16'h0000 and irq = 0.
REQ-036 The same reset SHALL set synchronizers, samples and debounced levels to the idle state: keys released, switches off.
REQ-037 Reset asserted mid-operation SHALL discard all queued and pending events, with no partial entry remaining.
REQ-038 Sources that are active when reset releases SHALL generate events through normal debouncing, at the earliest 2 ticks after release.

Verification (DEBOUNCE_CYCLES=4, FIFO_DEPTH=8)
REQ-039 Scenario: drive keys_in[2]=0 steadily for 12 cycles -> irq rises; reading BASE+1 yields 16'h8002 one cycle later; irq falls.
REQ-040 Scenario: toggle sw_in[0] every 2 cycles for 20 cycles, then hold it low -> no event is enqueued and LEVEL bit 4 stays 0.
REQ-041 Scenario: set sw_in[1] and sw_in[0] in the same cycle -> the FIFO holds 16'h8004 then 16'h8005, in that order.
REQ-042 Scenario: generate 10 events without reading -> STATUS = 16'h0087 (count 8, overflow, full, not_empty); write BASE+0 with wdata 16'h000C -> STATUS = 16'h0000.
REQ-043 Scenario: read BASE+1 with the FIFO empty -> rdata = 16'h0000 and count stays 0; read address 16'h0000 -> rdata = 16'h0000.
REQ-044 Scenario: 3 events queued, then reset pulsed low for 1 cycle -> STATUS = 16'h0000, irq = 0, and no stale events appear afterwards.
